// File: rtl/pwrmgmt_sib_access_seq.sv
// pwrmgmt_sib_access_seq: turns one parallel request into a SIB open / data capture-shift-update / SIB close IJTAG access; PWRMGMT_SEQ_READBACK_EN enables rdata capture and rd_err
module pwrmgmt_sib_access_seq #(
  parameter int DATA_W = 8
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_rst,
  input  logic              req,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
`ifdef PWRMGMT_SEQ_READBACK_EN
  output logic              rd_err,
`endif
  output logic              ijtag_sel,
  output logic              ijtag_ce,
  output logic              ijtag_se,
  output logic              ijtag_ue,
  output logic              ijtag_si,
  input  logic              ijtag_so
);
  localparam int CW = $clog2(DATA_W + 2);
  typedef enum logic [3:0] {
    IDLE, O_CAP, O_SHIFT, O_UPD, O_SETTLE, D_CAP, D_SHIFT, D_UPD, C_SETTLE, DONE
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W:0] wsh_q, wsh_d;
  logic sel_q, ce_q, se_q, ue_q, si_q;
  logic sel_d, ce_d, se_d, ue_d, si_d;
  logic accept;
  assign accept = (state_q == IDLE) && req;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign ijtag_sel = sel_q;
  assign ijtag_ce = ce_q;
  assign ijtag_se = se_q;
  assign ijtag_ue = ue_q;
  assign ijtag_si = si_q;
  // next state, shared settle/bit counter, write shifter and scan decode of the state about to be entered
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req) state_d = O_CAP;
      O_CAP:    state_d = O_SHIFT;
      O_SHIFT:  state_d = O_UPD;
      O_UPD:    state_d = O_SETTLE;
      O_SETTLE: if (cnt_q == CW'(1)) state_d = D_CAP;
      D_CAP:    state_d = D_SHIFT;
      D_SHIFT:  if (cnt_q == CW'(DATA_W)) state_d = D_UPD;
      D_UPD:    state_d = C_SETTLE;
      C_SETTLE: if (cnt_q == CW'(1)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(cnt_q != CW'(DATA_W));
    wsh_d = accept ? {req_wdata, 1'b0} : (state_d == D_SHIFT) ? {1'b0, wsh_q[DATA_W:1]} : wsh_q;
    sel_d = state_d inside {O_CAP, O_SHIFT, O_UPD, O_SETTLE, D_CAP, D_SHIFT, D_UPD};
    ce_d = state_d inside {O_CAP, D_CAP};
    se_d = state_d inside {O_SHIFT, D_SHIFT};
    ue_d = state_d inside {O_UPD, D_UPD};
    si_d = (state_d == O_SHIFT) || ((state_d == D_SHIFT) && wsh_q[0]);
  end
  // state, counter and write shifter advance on the rising edge
  always_ff @(posedge ijtag_tck or posedge ijtag_rst) begin
    if (ijtag_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wsh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wsh_q <= wsh_d;
    end
  end
  // scan controls for the next state launch on the falling edge, half a cycle ahead of the SIB sample
  always_ff @(negedge ijtag_tck or posedge ijtag_rst) begin
    if (ijtag_rst) begin
      sel_q <= 1'b0;
      ce_q <= 1'b0;
      se_q <= 1'b0;
      ue_q <= 1'b0;
      si_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      ce_q <= ce_d;
      se_q <= se_d;
      ue_q <= ue_d;
      si_q <= si_d;
    end
  end
`ifdef PWRMGMT_SEQ_READBACK_EN
  logic [DATA_W:0] rsh_q, rsh_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic rd_err_q, rd_err_d;
  assign rdata = rdata_q;
  assign rd_err = rd_err_q;
  // collect ijtag_so on each shift edge; sample 0 is the SIB bit, the rest is the register, published entering DONE
  always_comb begin
    rsh_d = (state_d == D_SHIFT) ? {ijtag_so, rsh_q[DATA_W:1]} : rsh_q;
    rdata_d = (state_d == DONE) ? rsh_q[DATA_W:1] : rdata_q;
    rd_err_d = (state_d == DONE) ? rsh_q[0] : accept ? 1'b0 : rd_err_q;
  end
  // readback registers
  always_ff @(posedge ijtag_tck or posedge ijtag_rst) begin
    if (ijtag_rst) begin
      rsh_q <= '0;
      rdata_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      rsh_q <= rsh_d;
      rdata_q <= rdata_d;
      rd_err_q <= rd_err_d;
    end
  end
`else
  logic unused_so;
  assign unused_so = ijtag_so;
  assign rdata = '0;
`endif
endmodule

// File: tb/tb_pwrmgmt_sib_access_seq.sv
// tb_pwrmgmt_sib_access_seq: directed bench with SIB + data segment models for DATA_W=8 and DATA_W=1
module tb_pwrmgmt_sib_access_seq;
`ifdef PWRMGMT_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic tck, rst;
  logic a_req, a_busy, a_done, a_err, a_sel, a_ce, a_se, a_ue, a_si, a_so;
  logic [7:0] a_wd, a_rdata;
  logic b_req, b_busy, b_done, b_err, b_sel, b_ce, b_se, b_ue, b_si, b_so;
  logic [0:0] b_wd, b_rdata;
  logic a_sh, a_upd, b_sh, b_upd, a_stuck, mclr, mpre;
  logic [7:0] a_seg, a_pre, a_seq, b_seq;
  logic [0:0] b_seg, b_pre;
  int a_nse, b_nse;
  int total, bad;

  pwrmgmt_sib_access_seq #(.DATA_W(8)) u_a (
    .ijtag_tck(tck), .ijtag_rst(rst), .req(a_req), .req_wdata(a_wd),
    .busy(a_busy), .done(a_done), .rdata(a_rdata),
`ifdef PWRMGMT_SEQ_READBACK_EN
    .rd_err(a_err),
`endif
    .ijtag_sel(a_sel), .ijtag_ce(a_ce), .ijtag_se(a_se), .ijtag_ue(a_ue),
    .ijtag_si(a_si), .ijtag_so(a_so));

  pwrmgmt_sib_access_seq #(.DATA_W(1)) u_b (
    .ijtag_tck(tck), .ijtag_rst(rst), .req(b_req), .req_wdata(b_wd),
    .busy(b_busy), .done(b_done), .rdata(b_rdata),
`ifdef PWRMGMT_SEQ_READBACK_EN
    .rd_err(b_err),
`endif
    .ijtag_sel(b_sel), .ijtag_ce(b_ce), .ijtag_se(b_se), .ijtag_ue(b_ue),
    .ijtag_si(b_si), .ijtag_so(b_so));

`ifndef PWRMGMT_SEQ_READBACK_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  initial tck = 1'b0;
  always #5 tck = ~tck;

  assign a_so = a_stuck | a_sh;
  assign b_so = b_sh;

  // SIB (capture clears, update opens/closes) in front of the data segment; bit 0 sits next to from_so
  always @(posedge tck or posedge rst) begin
    if (rst) begin
      a_sh <= 1'b0; a_upd <= 1'b0; b_sh <= 1'b0; b_upd <= 1'b0;
    end else begin
      if (mclr) begin a_seq <= '0; a_nse <= 0; b_seq <= '0; b_nse <= 0; end
      if (mpre) begin a_seg <= a_pre; b_seg <= b_pre; end
      if (a_sel) begin
        if (a_ce) a_sh <= 1'b0;
        if (a_se) begin
          a_seq <= {a_seq[6:0], a_si}; a_nse <= a_nse + 1;
          if (a_upd) begin a_sh <= a_seg[0]; a_seg <= {a_si, a_seg[7:1]}; end
          else a_sh <= a_si;
        end
        if (a_ue) a_upd <= a_sh;
      end
      if (b_sel) begin
        if (b_ce) b_sh <= 1'b0;
        if (b_se) begin
          b_seq <= {b_seq[6:0], b_si}; b_nse <= b_nse + 1;
          if (b_upd) begin b_sh <= b_seg[0]; b_seg <= b_si; end
          else b_sh <= b_si;
        end
        if (b_ue) b_upd <= b_sh;
      end
    end
  end

  task automatic preload(input logic [7:0] av, input logic [0:0] bv);
    a_pre = av; b_pre = bv; mpre = 1'b1;
    @(posedge tck); #1 mpre = 1'b0;
  endtask

  task automatic run(input bit b, input logic [7:0] wd, input int pulse_edge,
                     output int done_at, output int ndone, output int nbusy,
                     output logic [7:0] rd, output logic err_acc, output logic err_done);
    mclr = 1'b1;
    @(posedge tck); #1 mclr = 1'b0;
    a_wd = wd; b_wd = wd[0:0];
    if (b) b_req = 1'b1; else a_req = 1'b1;
    @(posedge tck); #1 a_req = 1'b0; b_req = 1'b0;
    err_acc = b ? b_err : a_err;
    done_at = -1; ndone = 0; nbusy = 0; rd = '0; err_done = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == pulse_edge) a_req = 1'b1;
      @(posedge tck); #1;
      if (k == pulse_edge) a_req = 1'b0;
      if (b ? b_busy : a_busy) nbusy++;
      if (b ? b_done : a_done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = k;
          rd = b ? {7'b0, b_rdata} : a_rdata;
          err_done = b ? b_err : a_err;
        end
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if ({a_busy, a_done, a_sel, a_ce, a_se, a_ue, a_si} !== 7'b0) begin bad++; $display("FAIL reset_a_outs: got %b want 0000000", {a_busy, a_done, a_sel, a_ce, a_se, a_ue, a_si}); end
    total++; if ({b_busy, b_done, b_sel, b_ce, b_se, b_ue, b_si} !== 7'b0) begin bad++; $display("FAIL reset_b_outs: got %b want 0000000", {b_busy, b_done, b_sel, b_ce, b_se, b_ue, b_si}); end
    total++; if ({a_rdata, b_rdata, a_err, b_err} !== 11'b0) begin bad++; $display("FAIL reset_rdata_err: got %h want 000", {a_rdata, b_rdata, a_err, b_err}); end
    @(posedge tck); #1 rst = 1'b0;
    preload(8'h00, 1'b0);
  endtask

  task automatic test_open_write_close();
    int da, nd, nb; logic [7:0] rd; logic ea, ed;
    run(1'b0, 8'hA5, 0, da, nd, nb, rd, ea, ed);
    total++; if (da !== 18) begin bad++; $display("FAIL owc_done_cycle: got %0d want 18", da); end
    total++; if (nd !== 1) begin bad++; $display("FAIL owc_done_count: got %0d want 1", nd); end
    total++; if (nb !== 18) begin bad++; $display("FAIL owc_busy_cycles: got %0d want 18", nb); end
    total++; if (a_nse !== 10) begin bad++; $display("FAIL owc_shift_count: got %0d want 10", a_nse); end
    total++; if (a_seq[7:0] !== 8'hA5 || a_nse < 10) begin bad++; $display("FAIL owc_si_tail: got %h want a5", a_seq); end
    total++; if (a_seg !== 8'hA5) begin bad++; $display("FAIL owc_segment: got %h want a5", a_seg); end
    total++; if (a_upd !== 1'b0) begin bad++; $display("FAIL owc_sib_closed: got %b want 0", a_upd); end
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL owc_rdata: got %h want 00", rd); end
  endtask

  task automatic test_si_sequence();
    int da, nd, nb; logic [7:0] rd; logic ea, ed; logic [15:0] seq;
    seq = '0;
    mclr = 1'b1;
    @(posedge tck); #1 mclr = 1'b0;
    a_wd = 8'hA5; a_req = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge tck);
      if (k == 0) begin #1 a_req = 1'b0; end
      if (a_se && a_sel) seq = {seq[14:0], a_si};
    end
    total++; if (seq[9:0] !== 10'b1010100101) begin bad++; $display("FAIL si_sequence: got %b want 1010100101", seq[9:0]); end
    repeat (12) @(posedge tck);
    #1;
    run(1'b0, 8'h00, 0, da, nd, nb, rd, ea, ed);
  endtask

  task automatic test_readback();
    int da, nd, nb; logic [7:0] rd; logic ea, ed;
    preload(8'h3C, 1'b0);
    run(1'b0, 8'h00, 0, da, nd, nb, rd, ea, ed);
    total++; if (rd !== (RB ? 8'h3C : 8'h00)) begin bad++; $display("FAIL rb_rdata: got %h want %h", rd, RB ? 8'h3C : 8'h00); end
    total++; if (a_rdata !== (RB ? 8'h3C : 8'h00)) begin bad++; $display("FAIL rb_rdata_held: got %h want %h", a_rdata, RB ? 8'h3C : 8'h00); end
    total++; if (ed !== 1'b0) begin bad++; $display("FAIL rb_err: got %b want 0", ed); end
    total++; if (a_seg !== 8'h00) begin bad++; $display("FAIL rb_segment: got %h want 00", a_seg); end
  endtask

  task automatic test_busy_overlap();
    int da, nd, nb, d1, d2; logic [7:0] rd; logic ea, ed; logic busy19;
    run(1'b0, 8'h5A, 6, da, nd, nb, rd, ea, ed);
    total++; if (nd !== 1) begin bad++; $display("FAIL ovl_done_count: got %0d want 1", nd); end
    total++; if (da !== 18) begin bad++; $display("FAIL ovl_done_cycle: got %0d want 18", da); end
    total++; if (a_seg !== 8'h5A) begin bad++; $display("FAIL ovl_segment: got %h want 5a", a_seg); end
    a_wd = 8'h96; a_req = 1'b1;
    @(posedge tck); #1;
    d1 = -1; d2 = -1; nd = 0; busy19 = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge tck); #1;
      if (k == 20) a_req = 1'b0;
      if (k == 19) busy19 = a_busy;
      if (a_done) begin
        nd++;
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
    end
    total++; if (d1 !== 18 || d2 !== 38) begin bad++; $display("FAIL held_done_cycles: got %0d,%0d want 18,38", d1, d2); end
    total++; if (nd !== 2) begin bad++; $display("FAIL held_done_count: got %0d want 2", nd); end
    total++; if (busy19 !== 1'b0) begin bad++; $display("FAIL held_idle_gap: got %b want 0", busy19); end
    total++; if (a_seg !== 8'h96) begin bad++; $display("FAIL held_segment: got %h want 96", a_seg); end
  endtask

  task automatic test_stuck_sib();
    int da, nd, nb; logic [7:0] rd; logic ea, ed;
    a_stuck = 1'b1;
    run(1'b0, 8'h11, 0, da, nd, nb, rd, ea, ed);
    a_stuck = 1'b0;
    total++; if (ed !== RB) begin bad++; $display("FAIL stuck_err_at_done: got %b want %b", ed, RB); end
    total++; if (a_err !== RB) begin bad++; $display("FAIL stuck_err_held: got %b want %b", a_err, RB); end
    total++; if (rd !== (RB ? 8'hFF : 8'h00)) begin bad++; $display("FAIL stuck_rdata: got %h want %h", rd, RB ? 8'hFF : 8'h00); end
    run(1'b0, 8'h22, 0, da, nd, nb, rd, ea, ed);
    total++; if (ea !== 1'b0) begin bad++; $display("FAIL stuck_err_cleared: got %b want 0", ea); end
    total++; if (ed !== 1'b0 || da !== 18) begin bad++; $display("FAIL stuck_next_access: got err=%b done=%0d want err=0 done=18", ed, da); end
  endtask

  task automatic test_reset_mid_shift();
    int da, nd, nb, nz; logic [7:0] rd; logic ea, ed;
    a_wd = 8'h77; a_req = 1'b1;
    @(posedge tck); #1 a_req = 1'b0;
    repeat (10) @(posedge tck);
    #3;
    total++; if ({a_busy, a_sel, a_se} !== 3'b111) begin bad++; $display("FAIL mid_in_shift: got %b want 111", {a_busy, a_sel, a_se}); end
    rst = 1'b1; #1;
    total++; if ({a_busy, a_done, a_sel, a_ce, a_se, a_ue, a_si} !== 7'b0) begin bad++; $display("FAIL mid_reset_outs: got %b want 0000000", {a_busy, a_done, a_sel, a_ce, a_se, a_ue, a_si}); end
    total++; if ({a_rdata, a_err} !== 9'b0) begin bad++; $display("FAIL mid_reset_rdata: got %h want 000", {a_rdata, a_err}); end
    @(posedge tck); #1 rst = 1'b0;
    nz = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge tck); #1;
      if (a_done || a_busy) nz++;
    end
    total++; if (nz !== 0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", nz); end
    run(1'b0, 8'hC3, 0, da, nd, nb, rd, ea, ed);
    total++; if (da !== 18 || nd !== 1) begin bad++; $display("FAIL mid_recover_done: got %0d/%0d want 18/1", da, nd); end
    total++; if (a_seg !== 8'hC3 || a_upd !== 1'b0) begin bad++; $display("FAIL mid_recover_seg: got %h/%b want c3/0", a_seg, a_upd); end
  endtask

  task automatic test_data_w1();
    int da, nd, nb; logic [7:0] rd; logic ea, ed;
    run(1'b1, 8'h01, 0, da, nd, nb, rd, ea, ed);
    total++; if (da !== 11 || nd !== 1) begin bad++; $display("FAIL w1_done: got %0d/%0d want 11/1", da, nd); end
    total++; if (b_nse !== 3 || b_seq[2:0] !== 3'b101) begin bad++; $display("FAIL w1_si: got n=%0d seq=%b want n=3 seq=101", b_nse, b_seq[2:0]); end
    total++; if (b_seg !== 1'b1 || b_upd !== 1'b0) begin bad++; $display("FAIL w1_seg: got %b/%b want 1/0", b_seg, b_upd); end
    run(1'b1, 8'h00, 0, da, nd, nb, rd, ea, ed);
    total++; if (da !== 11 || nb !== 11) begin bad++; $display("FAIL w1_again: got done=%0d busy=%0d want 11/11", da, nb); end
    total++; if (rd !== {7'b0, RB}) begin bad++; $display("FAIL w1_rdata: got %h want %h", rd, {7'b0, RB}); end
    total++; if (b_seg !== 1'b0 || b_seq[2:0] !== 3'b100) begin bad++; $display("FAIL w1_seg2: got %b/%b want 0/100", b_seg, b_seq[2:0]); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_wd = '0; b_wd = '0;
    a_stuck = 1'b0; mclr = 1'b0; mpre = 1'b0; a_pre = '0; b_pre = '0;
    test_reset();
    test_open_write_close();
    test_si_sequence();
    test_readback();
    test_busy_overlap();
    test_stuck_sib();
    test_reset_mid_shift();
    test_data_w1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwrmgmt_sib_access_seq.md
# pwrmgmt_sib_access_seq

Sequencer that owns the IJTAG port of the power-management SIB array segment and turns a single parallel request into a full scan access: open the SIB, capture/shift/update the `DATA_W`-bit power-management data register behind it, and close the SIB again in the same shift. It sits between the on-chip power controller and the `firebird7_in_gate1` SIB for the power-management segment. It replaces manual IJTAG pattern application for in-system power-state reconfiguration.

## Interface
- `DATA_W`, default 8: length of the power-management data register behind the SIB. Legal range is 1..64.
- `ijtag_tck`  in  1  scan clock. The state register uses the rising edge. Scan control outputs are launched from the falling edge.
- `ijtag_rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  access request. Sampled only in IDLE.
- `req_wdata`  in  DATA_W  value to load into the data register. Captured when `req` is accepted.
- `busy`  out  1  high from the accepting edge until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  data register contents captured during this access. Held until the next `done`.
- `ijtag_sel`, `ijtag_ce`, `ijtag_se`, `ijtag_ue`, `ijtag_si`  out  1 each  scan controls and data toward the SIB.
- `ijtag_so`  in  1  SIB scan output.

## Operation
- States, in order: IDLE, O_CAP (1 cycle), O_SHIFT (1), O_UPD (1), O_SETTLE (2), D_CAP (1), D_SHIFT (DATA_W+1), D_UPD (1), C_SETTLE (2), DONE (1), then back to IDLE.
- Open phase:
  - The SIB is closed, so the chain is 1 bit long.
  - O_SHIFT shifts `ijtag_si`=1.
  - O_UPD sets the SIB latch.
  - O_SETTLE covers the SIB's two falling-edge delay before `to_sel` reaches the segment.
- Data phase:
  - The chain is the SIB bit plus DATA_W bits.
  - Shift order on `ijtag_si`: first the SIB bit 0 (auto-close), then `req_wdata[0]`, `req_wdata[1]`, …, `req_wdata[DATA_W-1]`.
  - Bit 0 of the data register is the cell nearest the SIB's `from_so` input.
- Readback:
  - The controller samples `ijtag_so` on every D_SHIFT rising edge.
  - Sample 0 is the SIB bit, which must read 0 because capture clears it.
  - Samples 1..DATA_W fill `rdata[0..DATA_W-1]`.
- Close phase: D_UPD loads SIB=0. C_SETTLE lets `to_sel` drop before `done`.
- Scan control encoding per state:
  - `ijtag_sel`=1 in every state from O_CAP through D_UPD. It is 0 in all other states.
  - `ijtag_ce` is 1 only in O_CAP and D_CAP.
  - `ijtag_se` is 1 only in O_SHIFT and D_SHIFT.
  - `ijtag_ue` is 1 only in O_UPD and D_UPD.
  - `ijtag_si` is 0 outside shift states.
- `req` while busy is ignored; it is not queued. A new `req` is accepted in the IDLE cycle that follows DONE.
- A bit counter of ceil(log2(DATA_W+2)) bits counts 0..DATA_W in D_SHIFT and saturates there.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`, `done` and all scan outputs = 0.
  - `rdata` = 0.
- Reset takes effect asynchronously mid-operation. The SIB itself is reset independently through its own IJTAG reset. The controller does not attempt any closing scan after reset.
- Acceptance and latency:
  - `req` is accepted at rising edge 0. O_CAP begins in that cycle.
  - `done` is high in cycle DATA_W+10 after edge 0.
  - `rdata` updates on the same edge that raises `done`.
- Scan launch: the scan controls for a state are launched on the falling edge in the middle of the previous state's cycle. They are therefore stable at the SIB's rising-edge sample, with half a cycle of setup and hold.

## Configuration
- `PWRMGMT_SEQ_READBACK_EN`:
  - Defined: `rdata` is captured as described, and output `rd_err` (1 bit, reset 0) is added. `rd_err` goes high with `done` if shift sample 0 was 1, which means the SIB failed to open or capture, and stays high until the next accepted `req`.
  - Undefined: `ijtag_so` is unused, `rdata` is tied to 0, and `rd_err` is absent.

## Test plan
- Open/write/close, DATA_W=8:
  - Stimulus: `req_wdata`=0xA5.
  - Required: the `ijtag_si` serial sequence is 1 (open), then 0,1,0,1,0,0,1,0,1.
  - Required: `done` at cycle 18.
  - Required: the segment register holds 0xA5 and the SIB is closed afterward.
- Readback:
  - Stimulus: preload the segment with 0x3C, then request 0x00.
  - Required: `rdata`=0x3C, `rd_err`=0, segment=0x00.
- Busy overlap: a second `req` pulsed in cycle 5 is ignored; exactly one `done`. A `req` held high through DONE is accepted once more in the following IDLE cycle.
- Stuck SIB: force `ijtag_so`=1 during D_SHIFT. Required: `rd_err`=1 with `done`, and `rd_err`=0 after the next `req`.
- Reset mid-shift: assert `ijtag_rst` in D_SHIFT bit 4. Required: all outputs are 0 immediately, no `done`, and the next `req` completes normally.
- DATA_W=1 corner:
  - Required: a 2-bit data shift and `done` at cycle 11.
  - Required: the counter does not overflow.
